// File: rtl/clut_cycle.sv
// Colour-cycling controller for the CLUT system port: rotates a palette range up by
// one entry via read-modify-write and arbitrates CPU palette accesses onto the same port.
module clut_cycle #(
  parameter int unsigned ADDRW = 8,
  parameter int unsigned DATAW = 15
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             start,
  input  logic             cyc_en,
  input  logic [ADDRW-1:0] cyc_lo,
  input  logic [ADDRW-1:0] cyc_hi,
  output logic             busy,
  output logic             done,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [ADDRW-1:0] cpu_addr,
  input  logic [DATAW-1:0] cpu_din,
  output logic             cpu_ack,
  output logic [DATAW-1:0] cpu_dout,
  output logic             clut_re,
  output logic             clut_we,
  output logic [ADDRW-1:0] clut_addr,
  output logic [DATAW-1:0] clut_din,
  input  logic [DATAW-1:0] clut_dout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HOLD = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_LAST = 3'd4,
    S_CACK = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [ADDRW-1:0] lo, hi, idx;
  logic [DATAW-1:0] hold;
  logic             pend;

  logic             acc_start_c;
  logic             rot_go_c;
  logic [ADDRW-1:0] idx_dec_c;
  logic [ADDRW-1:0] rot_hi_c;

  assign acc_start_c = start & cyc_en & (cyc_lo < cyc_hi);
  assign rot_go_c    = acc_start_c | pend;
  assign idx_dec_c   = idx - ADDRW'(1);
  // A live start supplies the range; a pending restart reuses the latched one.
  assign rot_hi_c    = acc_start_c ? cyc_hi : hi;

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Range, walking index, wrap-around word and the single-deep restart flag.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      lo   <= '0;
      hi   <= '0;
      idx  <= '0;
      hold <= '0;
      pend <= 1'b0;
    end else begin
      if (state != S_IDLE) begin
        if (acc_start_c) pend <= 1'b1;
      end else if (rot_go_c) begin
        pend <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (acc_start_c) begin
            lo <= cyc_lo;
            hi <= cyc_hi;
          end
        end
        S_HOLD: begin
          hold <= clut_dout;
          idx  <= hi;
        end
        S_WR:    idx <= idx_dec_c;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (rot_go_c)     state_nx = S_HOLD;
        else if (cpu_req) state_nx = S_CACK;
      end
      S_HOLD:  state_nx = S_WR;
      S_WR:    state_nx = (idx_dec_c == lo) ? S_LAST : S_RD;
      S_RD:    state_nx = S_WR;
      S_LAST:  state_nx = S_IDLE;
      S_CACK:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Port strobes and status; everything is forced low while reset is held.
  always_comb begin
    clut_re   = 1'b0;
    clut_we   = 1'b0;
    clut_addr = '0;
    clut_din  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    cpu_ack   = 1'b0;
    cpu_dout  = clut_dout;
    case (state)
      S_IDLE: begin
        if (rot_go_c) begin
          clut_re   = 1'b1;
          clut_addr = rot_hi_c;
        end else if (cpu_req) begin
          clut_re   = ~cpu_we;
          clut_we   = cpu_we;
          clut_addr = cpu_addr;
          clut_din  = cpu_din;
        end
      end
      S_HOLD: begin
        busy      = 1'b1;
        clut_re   = 1'b1;
        clut_addr = hi - ADDRW'(1);
      end
      S_WR: begin
        busy      = 1'b1;
        clut_we   = 1'b1;
        clut_addr = idx;
        clut_din  = clut_dout;
      end
      S_RD: begin
        busy      = 1'b1;
        clut_re   = 1'b1;
        clut_addr = idx_dec_c;
      end
      S_LAST: begin
        busy      = 1'b1;
        done      = 1'b1;
        clut_we   = 1'b1;
        clut_addr = lo;
        clut_din  = hold;
      end
      S_CACK:  cpu_ack = 1'b1;
      default: ;
    endcase
    if (rst_sys) begin
      clut_re   = 1'b0;
      clut_we   = 1'b0;
      clut_addr = '0;
      clut_din  = '0;
      busy      = 1'b0;
      done      = 1'b0;
      cpu_ack   = 1'b0;
      cpu_dout  = '0;
    end
  end

endmodule

// File: tb/tb_clut_cycle.sv
// Bench for clut_cycle: a simple synchronous palette RAM on the system port, a
// transaction-level reference model of rotations and CPU accesses, and directed tests.
module tb_clut_cycle;
  localparam int unsigned ADDRW = 8;
  localparam int unsigned DATAW = 15;

  logic             clk_sys = 1'b0;
  logic             rst_sys = 1'b1;
  logic             start = 1'b0, cyc_en = 1'b0;
  logic [ADDRW-1:0] cyc_lo = '0, cyc_hi = '0;
  logic             busy, done;
  logic             cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDRW-1:0] cpu_addr = '0;
  logic [DATAW-1:0] cpu_din = '0;
  logic             cpu_ack;
  logic [DATAW-1:0] cpu_dout;
  logic             clut_re, clut_we;
  logic [ADDRW-1:0] clut_addr;
  logic [DATAW-1:0] clut_din;
  logic [DATAW-1:0] clut_dout;

  clut_cycle #(.ADDRW(ADDRW), .DATAW(DATAW)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .start(start), .cyc_en(cyc_en),
    .cyc_lo(cyc_lo), .cyc_hi(cyc_hi), .busy(busy), .done(done),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout), .clut_re(clut_re), .clut_we(clut_we),
    .clut_addr(clut_addr), .clut_din(clut_din), .clut_dout(clut_dout)
  );

  always #5 clk_sys = ~clk_sys;

  // Palette RAM: read data appears one cycle after re.
  logic [DATAW-1:0] ram [256];
  logic [DATAW-1:0] ram_q = '0;
  always @(posedge clk_sys) begin
    if (clut_we) ram[clut_addr] <= clut_din;
    if (clut_re) ram_q <= ram[clut_addr];
  end
  assign clut_dout = ram_q;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: palette contents plus remaining-busy counter per transaction.
  logic [DATAW-1:0] m_pal [256];
  int               m_cnt = 0;
  bit               m_pend = 1'b0, m_ack = 1'b0, m_rd = 1'b0;
  logic [ADDRW-1:0] m_lo = '0, m_hi = '0;
  logic [DATAW-1:0] m_rdata = '0;

  always @(posedge clk_sys) begin
    bit acc, idle;
    logic [DATAW-1:0] top;
    acc = start && cyc_en && (cyc_lo < cyc_hi);
    if (rst_sys) begin
      m_cnt = 0; m_pend = 1'b0; m_ack = 1'b0; m_rd = 1'b0;
      for (int i = 0; i < 256; i++) m_pal[i] = ram[i];
    end else begin
      idle = (m_cnt == 0) && !m_ack;
      if (idle) begin
        if (acc || m_pend) begin
          if (acc) begin m_lo = cyc_lo; m_hi = cyc_hi; end
          m_pend = 1'b0;
          m_cnt = 2 * (int'(m_hi) - int'(m_lo)) + 1;
          top = m_pal[m_hi];
          for (int i = int'(m_hi); i > int'(m_lo); i--) m_pal[i] = m_pal[i-1];
          m_pal[m_lo] = top;
        end else if (cpu_req) begin
          m_ack = 1'b1;
          m_rd = !cpu_we;
          if (cpu_we) m_pal[cpu_addr] = cpu_din;
          else m_rdata = m_pal[cpu_addr];
        end
      end else begin
        if (acc) m_pend = 1'b1;
        if (m_cnt > 0) m_cnt--;
        else m_ack = 1'b0;
      end
    end
  end

  // Per-cycle compare plus activity counters used by the directed tests.
  int cyc = 0, busy_cnt = 0, done_cnt = 0, we_cnt = 0, last_done = 0, last_ack = 0;
  always @(negedge clk_sys) begin
    cyc++;
    chk("busy", int'(busy), int'(!rst_sys && m_cnt > 0));
    chk("done", int'(done), int'(!rst_sys && m_cnt == 1));
    chk("cpu_ack", int'(cpu_ack), int'(!rst_sys && m_ack));
    if (!rst_sys && m_ack && m_rd) chk("cpu_dout", int'(cpu_dout), int'(m_rdata));
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; last_done = cyc; end
    if (cpu_ack) last_ack = cyc;
    if (clut_we) we_cnt++;
  end

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic pulse_start(input bit en, input logic [ADDRW-1:0] lo, input logic [ADDRW-1:0] hi);
    cyc_en = en; cyc_lo = lo; cyc_hi = hi; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic cpu_xfer(input bit we, input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d,
                          output logic [DATAW-1:0] q, output int w);
    cpu_we = we; cpu_addr = a; cpu_din = d; cpu_req = 1'b1; w = 0;
    do begin @(negedge clk_sys); w++; end while (!cpu_ack && w < 3000);
    q = cpu_dout;
    if (!cpu_ack) chk("cpu_ack_timeout", 0, 1);
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic wait_quiet();
    int q = 0, n = 0;
    while (q < 4 && n < 3000) begin
      tick(); n++;
      q = (busy || cpu_ack) ? 0 : q + 1;
    end
    if (q < 4) chk("quiet_timeout", 0, 1);
  endtask

  task automatic preload8();
    logic [DATAW-1:0] q; int w;
    for (int i = 0; i < 8; i++) cpu_xfer(1'b1, ADDRW'(i), DATAW'(16'h100 + i), q, w);
  endtask

  task automatic cmp_model(input int n);
    for (int i = 0; i < n; i++) chk($sformatf("pal[%0d]", i), int'(ram[i]), int'(m_pal[i]));
  endtask

  function automatic logic [DATAW-1:0] pat(input int i);
    return DATAW'(32'h2000 + i * 5);
  endfunction

  initial begin
    logic [DATAW-1:0] q;
    int w, b0, d0, w0, k0;

    // Reset: strobes stay low even with a CPU request present.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd9;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_we", int'(clut_we), 0);
    chk("rst_re", int'(clut_re), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(cpu_ack), 0);
    cpu_req = 1'b0;
    tick();
    rst_sys = 1'b0;
    tick();

    // Basic rotation 2..5.
    preload8();
    b0 = busy_cnt; d0 = done_cnt;
    pulse_start(1'b1, 8'd2, 8'd5);
    wait_quiet();
    chk("t1_busy_cycles", busy_cnt - b0, 7);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_e2", int'(ram[2]), 'h105);
    chk("t1_e3", int'(ram[3]), 'h102);
    chk("t1_e4", int'(ram[4]), 'h103);
    chk("t1_e5", int'(ram[5]), 'h104);
    chk("t1_e1", int'(ram[1]), 'h101);
    chk("t1_e6", int'(ram[6]), 'h106);
    cmp_model(8);

    // CPU write raised one cycle after start waits for the rotation.
    d0 = done_cnt;
    fork
      pulse_start(1'b1, 8'd2, 8'd5);
      begin tick(); cpu_xfer(1'b1, 8'd3, 15'h7FFF, q, w); end
    join
    chk("t2_done_cnt", done_cnt - d0, 1);
    chk("t2_ack_after_done", int'(last_ack > last_done), 1);
    cpu_xfer(1'b0, 8'd3, '0, q, w);
    chk("t2_readback", int'(q), 'h7FFF);

    // Start and CPU read in the same cycle: rotation first, then read sees rotated data.
    d0 = done_cnt;
    fork
      pulse_start(1'b1, 8'd2, 8'd5);
      cpu_xfer(1'b0, 8'd2, '0, q, w);
    join
    chk("t3_done_cnt", done_cnt - d0, 1);
    chk("t3_ack_after_done", int'(last_ack > last_done), 1);
    chk("t3_read_e2", int'(q), 'h103);
    wait_quiet();
    cmp_model(8);

    // Ignored starts.
    w0 = we_cnt; b0 = busy_cnt; d0 = done_cnt;
    pulse_start(1'b0, 8'd2, 8'd5); repeat (4) tick();
    pulse_start(1'b1, 8'd4, 8'd4); repeat (4) tick();
    pulse_start(1'b1, 8'd6, 8'd2); repeat (4) tick();
    chk("t4_we_cnt", we_cnt - w0, 0);
    chk("t4_busy", busy_cnt - b0, 0);
    chk("t4_done", done_cnt - d0, 0);

    // Second start while busy: back-to-back repeat.
    preload8();
    b0 = busy_cnt; d0 = done_cnt;
    fork
      pulse_start(1'b1, 8'd2, 8'd5);
      begin repeat (3) tick(); pulse_start(1'b1, 8'd2, 8'd5); end
    join
    wait_quiet();
    chk("t5_e2", int'(ram[2]), 'h104);
    chk("t5_e3", int'(ram[3]), 'h105);
    chk("t5_e5", int'(ram[5]), 'h103);
    chk("t5_busy_cycles", busy_cnt - b0, 14);
    chk("t5_done_cnt", done_cnt - d0, 2);

    // Reset mid-rotation after the first write (entry 5 <= old 4).
    preload8();
    pulse_start(1'b1, 8'd2, 8'd5);
    repeat (3) tick();
    rst_sys = 1'b1;
    #1;
    chk("t6_we_in_rst", int'(clut_we), 0);
    chk("t6_busy_in_rst", int'(busy), 0);
    k0 = we_cnt;
    tick(); tick();
    rst_sys = 1'b0;
    wait_quiet();
    chk("t6_no_writes", we_cnt - k0, 0);
    cmp_model(8);
    cpu_xfer(1'b0, 8'd5, '0, q, w);
    chk("t6_read_e5", int'(q), 'h104);
    chk("t6_ack_latency", w, 2);
    cpu_xfer(1'b0, 8'd2, '0, q, w);
    chk("t6_read_e2", int'(q), 'h102);

    // Full range rotation.
    for (int i = 0; i < 256; i++) cpu_xfer(1'b1, ADDRW'(i), pat(i), q, w);
    b0 = busy_cnt; d0 = done_cnt;
    pulse_start(1'b1, 8'd0, 8'd255);
    wait_quiet();
    chk("t7_busy_cycles", busy_cnt - b0, 511);
    chk("t7_done_cnt", done_cnt - d0, 1);
    chk("t7_e0", int'(ram[0]), int'(pat(255)));
    chk("t7_e1", int'(ram[1]), int'(pat(0)));
    chk("t7_e255", int'(ram[255]), int'(pat(254)));
    cmp_model(256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
